// File: rtl/wb_ram_pipelined_if.sv
// Wishbone B4 pipelined bus bundle for wb_ram_pipelined.
// master drives cyc/stb/we/adr/sel/dat_i; slave drives dat_o/ack/err/stall.
interface wb_ram_pipelined_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) ();
  localparam int SEL_W = WORD_WIDTH / 8;

  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [SEL_W-1:0]      wb_sel_i;
  logic [WORD_WIDTH-1:0] wb_dat_i;
  logic [WORD_WIDTH-1:0] wb_dat_o;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic                  wb_stall_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  wb_stall_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output wb_stall_o
  );
endinterface

// File: rtl/wb_ram_pipelined.sv
// wb_ram_pipelined: Wishbone B4 pipelined RAM, byte lanes, fixed latency.
// Ports: clk, rstn_i (async low), wb (slave). Zero-fill: WB_RAM_ZERO_INIT_EN.
module wb_ram_pipelined #(
  parameter int DEPTH      = 1024,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input logic               clk,
  input logic               rstn_i,
  wb_ram_pipelined_if.slave wb
);
  localparam int SEL_W = WORD_WIDTH / 8;
  localparam int OFF   = $clog2(SEL_W);
  localparam int IW    = $clog2(DEPTH);

  typedef struct packed {
    logic v;
    logic err;
    logic we;
  } resp_t;

  logic                  stall;
  logic                  fill;
  logic                  accept;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         fill_idx;

  logic [WORD_WIDTH-1:0] mem   [DEPTH];
  logic [WORD_WIDTH-1:0] dpipe [LATENCY];
  resp_t                 pipe  [LATENCY];

  logic                  ack_q;
  logic                  err_q;
  logic [WORD_WIDTH-1:0] dat_q;

`ifdef WB_RAM_ZERO_INIT_EN
  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fill) cnt_q <= cnt_q + IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    fill    = 1'b0;
    unique case (state_q)
      INIT: begin
        stall = 1'b1;
        fill  = 1'b1;
        if (cnt_q == IW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: ;
    endcase
  end

  assign fill_idx = cnt_q;
`else
  assign stall    = 1'b0;
  assign fill     = 1'b0;
  assign fill_idx = '0;
`endif

  // Gating with rstn_i keeps a write from landing while reset is held.
  assign accept   = wb.wb_cyc_i & wb.wb_stb_i & ~stall & rstn_i;
  assign idx_full = wb.wb_adr_i >> OFF;
  assign in_range = (idx_full >> IW) == '0;
  assign idx      = idx_full[IW-1:0];

  // The array is read on every edge; only slots tagged as reads use it.
  always_ff @(posedge clk) begin
    dpipe[0] <= mem[idx];
    for (int k = 1; k < LATENCY; k++)
      dpipe[k] <= dpipe[k-1];
    if (fill && rstn_i) begin
      mem[fill_idx] <= '0;
    end else if (accept && in_range && wb.wb_we_i) begin
      for (int b = 0; b < SEL_W; b++)
        if (wb.wb_sel_i[b])
          mem[idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
    end
  end

  // Dropping cyc discards every in-flight response slot.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < LATENCY; k++)
        pipe[k] <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else if (!wb.wb_cyc_i) begin
      for (int k = 0; k < LATENCY; k++)
        pipe[k] <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      pipe[0] <= {accept, accept & ~in_range, wb.wb_we_i};
      for (int k = 1; k < LATENCY; k++)
        pipe[k] <= pipe[k-1];
      ack_q <= pipe[LATENCY-1].v & ~pipe[LATENCY-1].err;
      err_q <= pipe[LATENCY-1].v & pipe[LATENCY-1].err;
      if (pipe[LATENCY-1].v && !pipe[LATENCY-1].err &&
          !pipe[LATENCY-1].we)
        dat_q <= dpipe[LATENCY-1];
      else
        dat_q <= '0;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = stall;
endmodule

// File: tb/tb_wb_ram_pipelined.sv
// Self-checking bench for wb_ram_pipelined (LATENCY=3, DEPTH=1024).
// Table-driven requests with an in-order response scoreboard.
module tb_wb_ram_pipelined;
  localparam int DEPTH = 1024;
  localparam int WW    = 32;
  localparam int AW    = 32;
  localparam int LAT   = 3;
`ifdef WB_RAM_ZERO_INIT_EN
  localparam bit ZI = 1'b1;
`else
  localparam bit ZI = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    bit          err;
    logic [31:0] rdat;
  } vec_t;

  typedef struct {
    int          at;
    bit          err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn_i = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  int   resp_seen = 0;
  exp_t sb[$];
  vec_t vt[$];

  wb_ram_pipelined_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  wb_ram_pipelined #(
    .DEPTH(DEPTH), .WORD_WIDTH(WW),
    .ADDR_WIDTH(AW), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rstn_i(rstn_i),
    .wb(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic void check(bit ok, string name,
                                logic [31:0] act, logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc_cnt);
    end
  endfunction

  always @(negedge clk) begin
    if (rstn_i) begin
      while (sb.size() > 0 && sb[0].at < cyc_cnt) begin
        check(1'b0, "missing_resp", 32'h0, sb[0].at);
        void'(sb.pop_front());
      end
      if (bus.wb_ack_o || bus.wb_err_o) begin
        resp_seen++;
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_resp",
                {bus.wb_ack_o, bus.wb_err_o}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(cyc_cnt == e.at, "resp_cycle", cyc_cnt, e.at);
          check(bus.wb_err_o == e.err && bus.wb_ack_o == !e.err,
                "resp_kind", {bus.wb_ack_o, bus.wb_err_o},
                {!e.err, e.err});
          check(bus.wb_dat_o == e.data, "resp_data",
                bus.wb_dat_o, e.data);
        end
      end else begin
        check(bus.wb_dat_o == 32'h0, "dat_idle", bus.wb_dat_o, 0);
      end
    end
  end

  task automatic drive(bit we, logic [31:0] adr, logic [3:0] sel,
                       logic [31:0] wdat, bit err,
                       logic [31:0] rdat, bit push);
    exp_t e;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = wdat;
    @(negedge clk);
    check(bus.wb_stall_o == 1'b0, "stall_run", bus.wb_stall_o, 0);
    if (push) begin
      e.at   = cyc_cnt + 1 + LAT;
      e.err  = err;
      e.data = (err || we) ? 32'h0 : rdat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bus.wb_stb_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++)
      @(negedge clk);
    check(sb.size() == 0, "drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Release reset just after an edge; returns the count of stalled
  // negedges seen before stall drops (bounded).
  task automatic release_rst(output int n);
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * DEPTH + 8; i++) begin
      @(negedge clk);
      if (!bus.wb_stall_o) break;
      n++;
    end
  endtask

  initial begin
    int n;
    int seen0;
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen0;
    exp_t e;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_dat_i = '0;
    rstn_i = 1'b0;
    #1;
    check(bus.wb_ack_o == 0, "rst_ack", bus.wb_ack_o, 0);
    check(bus.wb_err_o == 0, "rst_err", bus.wb_err_o, 0);
    check(bus.wb_dat_o == 0, "rst_dat", bus.wb_dat_o, 0);
    check(bus.wb_stall_o == ZI, "rst_stall", bus.wb_stall_o, ZI);
    repeat (3) @(posedge clk);
    release_rst(n);
    check(n == (ZI ? DEPTH : 0), "init_stall_len", n,
          ZI ? DEPTH : 0);
    @(posedge clk);
    #1;

    vt.push_back('{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 0});
    vt.push_back('{1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF});
    vt.push_back('{1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 0});
    vt.push_back('{1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 1'b0, 0});
    vt.push_back('{1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h11BB33DD});
    vt.push_back('{1'b1, 32'h0, 4'hF, 32'h01234567, 1'b0, 0});
    vt.push_back('{1'b1, 32'h4, 4'hF, 32'h89ABCDEF, 1'b0, 0});
    vt.push_back('{1'b1, 32'h8, 4'hF, 32'hCAFEF00D, 1'b0, 0});
    vt.push_back('{1'b1, 32'hC, 4'hF, 32'h0BADC0DE, 1'b0, 0});
    vt.push_back('{1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h01234567});
    vt.push_back('{1'b0, 32'h4, 4'hF, 32'h0, 1'b0, 32'h89ABCDEF});
    vt.push_back('{1'b0, 32'h8, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D});
    vt.push_back('{1'b0, 32'hC, 4'hF, 32'h0, 1'b0, 32'h0BADC0DE});
    vt.push_back('{1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b1, 0});
    vt.push_back('{1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 0});
    vt.push_back('{1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h01234567});
    vt.push_back('{1'b0, 32'h13, 4'h1, 32'h0, 1'b0, 32'hDEADBEEF});
    vt.push_back('{1'b1, 32'h24, 4'hF, 32'h55AA55AA, 1'b0, 0});
    vt.push_back('{1'b1, 32'h24, 4'h0, 32'hFFFFFFFF, 1'b0, 0});
    vt.push_back('{1'b0, 32'h24, 4'hF, 32'h0, 1'b0, 32'h55AA55AA});
    vt.push_back('{1'b1, 32'h24, 4'h8, 32'h12345678, 1'b0, 0});
    vt.push_back('{1'b0, 32'h24, 4'hF, 32'h0, 1'b0, 32'h12AA55AA});
    vt.push_back('{1'b1, 32'hFFC, 4'hF, 32'h77777777, 1'b0, 0});
    vt.push_back('{1'b0, 32'hFFC, 4'hF, 32'h0, 1'b0, 32'h77777777});
    vt.push_back('{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0, 1'b1, 0});

    for (int i = 0; i < vt.size(); i++)
      drive(vt[i].we, vt[i].adr, vt[i].sel, vt[i].wdat,
            vt[i].err, vt[i].rdat, 1'b1);
    idle(1);
    drain();

    // Abort: two reads in flight, cyc dropped next cycle.
    // A write aborted the same way must still land in memory.
    seen0 = resp_seen;
    drive(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    drive(1'b0, 32'h14, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 32'h30, 4'hF, 32'h5A5A0001, 1'b0, 0, 1'b0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check(resp_seen == seen0, "abort_no_resp", resp_seen, seen0);
    drive(1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 32'h5A5A0001, 1'b1);
    drive(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    idle(1);
    drain();

    // Reset while an ack is on the bus and another read is in flight.
    drive(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    drive(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    idle(2);
    check(bus.wb_ack_o == 1'b1, "pre_reset_ack", bus.wb_ack_o, 1);
    rstn_i = 1'b0;
    #1;
    sb.delete();
    check(bus.wb_ack_o == 0, "midrst_ack", bus.wb_ack_o, 0);
    check(bus.wb_dat_o == 0, "midrst_dat", bus.wb_dat_o, 0);
    check(bus.wb_stall_o == ZI, "midrst_stall", bus.wb_stall_o, ZI);
    // Hold a read of 0x10 across the whole fill window.
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h10;
    bus.wb_sel_i = 4'hF;
    seen0 = resp_seen;
    release_rst(n);
    check(n == (ZI ? DEPTH : 0), "refill_stall_len", n,
          ZI ? DEPTH : 0);
    check(resp_seen == seen0, "no_resp_in_init", resp_seen, seen0);
    e.at   = cyc_cnt + 1 + LAT;
    e.err  = 1'b0;
    e.data = ZI ? 32'h0 : 32'hDEADBEEF;
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h20, 4'hF, 32'h0, 1'b0,
          ZI ? 32'h0 : 32'h11BB33DD, 1'b1);
    drive(1'b0, 32'h0, 4'hF, 32'h0, 1'b0,
          ZI ? 32'h0 : 32'h01234567, 1'b1);
    drive(1'b0, 32'hFFC, 4'hF, 32'h0, 1'b0,
          ZI ? 32'h0 : 32'h77777777, 1'b1);
    idle(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
